// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : UART register map, control bit indices and master FSM states.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int CTL_IRQ_ENAB = 0;
    localparam int CTL_TX_READY = 1;
    localparam int CTL_TX_BUSY  = 2;
    localparam int CTL_RX_AVAL  = 3;

    localparam logic [2:0] REG_CONTROL = 3'd0;
    localparam logic [2:0] REG_RX      = 3'd1;
    localparam logic [2:0] REG_TX      = 3'd2;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_GAP    = 3'd1,
        ST_POLL   = 3'd2,
        ST_DECIDE = 3'd3,
        ST_RX_RD  = 3'd4,
        ST_TX_WR  = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_byte_fifo.sv
// ============================================================================
// Module      : uart_byte_fifo
// Description : Synchronous FIFO, DEPTH x WIDTH, with full/empty flags.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module uart_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign full   = (r_count == (PTR_W+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign head   = r_mem[r_rd_ptr];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/uart_port_master.sv
// ============================================================================
// Module      : uart_port_master
// Description : Bus-master sequencer feeding the UART Tx buffer from a FIFO
//               and pulling received bytes into a one-entry holding register.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module uart_port_master
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int POLL_GAP   = 16,
    parameter int USE_IRQ    = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       rx_overrun,
    output logic       bus_cs,
    output logic       bus_rd,
    output logic       bus_wr,
    output logic [2:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata,
    input  logic       irq
);

    localparam int         GAP_W    = $clog2(POLL_GAP);
    localparam logic [7:0] INIT_CTL = (USE_IRQ != 0) ? 8'(1 << CTL_IRQ_ENAB) : 8'h00;

    state_t           r_state;
    state_t           w_next;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_rx_aval;
    logic             r_tx_busy;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [7:0]       w_head;
    logic             w_pop;
    logic             w_irq_go;
    logic             w_cs;
    logic             w_rd;
    logic             w_wr;
    logic [2:0]       w_addr;
    logic [7:0]       w_wdata;

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (tx_valid),
        .push_data (tx_data),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    assign tx_ready = !w_fifo_full;
    assign w_pop    = (r_state == ST_DECIDE) && (w_next == ST_TX_WR);
    assign w_irq_go = (USE_IRQ != 0) && irq && !rx_valid;

    // Bus strobes are decoded from the next state and registered, so each
    // access is visible for exactly the cycle spent in its state.
    always_comb begin
        w_next  = r_state;
        w_cs    = 1'b1;
        w_rd    = 1'b1;
        w_wr    = 1'b1;
        w_addr  = bus_addr;
        w_wdata = bus_wdata;
        case (r_state)
            ST_INIT: begin
                // First cycle after reset issues the write, second moves on.
                if (bus_wr) begin
                    w_cs    = 1'b0;
                    w_wr    = 1'b0;
                    w_addr  = REG_CONTROL;
                    w_wdata = INIT_CTL;
                end else begin
                    w_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_irq_go) begin
                    w_next = ST_RX_RD;
                    w_cs   = 1'b0;
                    w_rd   = 1'b0;
                    w_addr = REG_RX;
                end else if (r_gap_cnt == GAP_W'(POLL_GAP - 1)) begin
                    w_next = ST_POLL;
                    w_cs   = 1'b0;
                    w_rd   = 1'b0;
                    w_addr = REG_CONTROL;
                end
            end
            ST_POLL: w_next = ST_DECIDE;
            ST_DECIDE: begin
                if (r_rx_aval && !rx_valid) begin
                    w_next = ST_RX_RD;
                    w_cs   = 1'b0;
                    w_rd   = 1'b0;
                    w_addr = REG_RX;
                end else if (!w_fifo_empty && !r_tx_busy) begin
                    w_next  = ST_TX_WR;
                    w_cs    = 1'b0;
                    w_wr    = 1'b0;
                    w_addr  = REG_TX;
                    w_wdata = w_head;
                end else begin
                    w_next = ST_GAP;
                end
            end
            ST_RX_RD: w_next = ST_GAP;
            ST_TX_WR: w_next = ST_GAP;
            default:  w_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_INIT;
            bus_cs    <= 1'b1;
            bus_rd    <= 1'b1;
            bus_wr    <= 1'b1;
            bus_addr  <= 3'd0;
            bus_wdata <= 8'h00;
            r_gap_cnt <= '0;
            r_rx_aval <= 1'b0;
            r_tx_busy <= 1'b0;
        end else begin
            r_state   <= w_next;
            bus_cs    <= w_cs;
            bus_rd    <= w_rd;
            bus_wr    <= w_wr;
            bus_addr  <= w_addr;
            bus_wdata <= w_wdata;
            r_gap_cnt <= (r_state == ST_GAP && w_next == ST_GAP) ? r_gap_cnt + 1'b1 : '0;
            if (r_state == ST_POLL) begin
                r_rx_aval <= bus_rdata[CTL_RX_AVAL];
                r_tx_busy <= bus_rdata[CTL_TX_BUSY];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_valid   <= 1'b0;
            rx_data    <= 8'h00;
            rx_overrun <= 1'b0;
        end else begin
            if (r_state == ST_RX_RD) begin
                rx_valid <= 1'b1;
                rx_data  <= bus_rdata;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if ((irq || (r_state == ST_DECIDE && r_rx_aval)) && rx_valid && !rx_ready)
                rx_overrun <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_port_master.sv
// ============================================================================
// Module      : tb_uart_port_master
// Description : Self-checking bench with a behavioural UART register model.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_port_master;
    import uart_pkg::*;

    localparam int POLL_GAP = 16;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;

    logic       tx_valid0, tx_ready0, rx_valid0, rx_ready0, rx_overrun0;
    logic [7:0] tx_data0, rx_data0;
    logic       bus_cs0, bus_rd0, bus_wr0;
    logic [2:0] bus_addr0;
    logic [7:0] bus_wdata0, bus_rdata0;

    logic       tx_valid1, tx_ready1, rx_valid1, rx_ready1, rx_overrun1, irq1;
    logic [7:0] tx_data1, rx_data1;
    logic       bus_cs1, bus_rd1, bus_wr1;
    logic [2:0] bus_addr1;
    logic [7:0] bus_wdata1, bus_rdata1;

    uart_port_master #(.FIFO_DEPTH(4), .POLL_GAP(POLL_GAP), .USE_IRQ(0)) dut0 (
        .clock(clock), .reset(reset), .tx_valid(tx_valid0), .tx_data(tx_data0),
        .tx_ready(tx_ready0), .rx_valid(rx_valid0), .rx_data(rx_data0), .rx_ready(rx_ready0),
        .rx_overrun(rx_overrun0), .bus_cs(bus_cs0), .bus_rd(bus_rd0), .bus_wr(bus_wr0),
        .bus_addr(bus_addr0), .bus_wdata(bus_wdata0), .bus_rdata(bus_rdata0), .irq(1'b0));

    uart_port_master #(.FIFO_DEPTH(4), .POLL_GAP(POLL_GAP), .USE_IRQ(1)) dut1 (
        .clock(clock), .reset(reset), .tx_valid(tx_valid1), .tx_data(tx_data1),
        .tx_ready(tx_ready1), .rx_valid(rx_valid1), .rx_data(rx_data1), .rx_ready(rx_ready1),
        .rx_overrun(rx_overrun1), .bus_cs(bus_cs1), .bus_rd(bus_rd1), .bus_wr(bus_wr1),
        .bus_addr(bus_addr1), .bus_wdata(bus_wdata1), .bus_rdata(bus_rdata1), .irq(irq1));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out", name);
    endtask

    // UART register model for dut0
    logic       model_busy, rx_aval, rx_load;
    logic [7:0] rx_buf, rx_load_byte, rx_buf1;

    always_comb begin
        bus_rdata0 = 8'h00;
        if (bus_addr0 == REG_CONTROL) begin
            bus_rdata0[CTL_TX_BUSY]  = model_busy;
            bus_rdata0[CTL_TX_READY] = !model_busy;
            bus_rdata0[CTL_RX_AVAL]  = rx_aval;
        end else if (bus_addr0 == REG_RX) begin
            bus_rdata0 = rx_buf;
        end
    end

    always @(posedge clock) begin
        if (reset) begin
            rx_aval <= 1'b0;
            rx_buf  <= 8'h00;
        end else if (rx_load) begin
            rx_aval <= 1'b1;
            rx_buf  <= rx_load_byte;
        end else if (!bus_cs0 && !bus_rd0 && bus_addr0 == REG_RX) begin
            rx_aval <= 1'b0;
        end
    end

    // dut1 model: Tx always busy, rx data read through the interrupt path only
    assign bus_rdata1 = (bus_addr1 == REG_RX) ? rx_buf1 : 8'(1 << CTL_TX_BUSY);

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    int init_wr0 = 0, tx_wr0 = 0, rx_rd0 = 0, rx_rd1 = 0, npoll = 0;
    int polls_since_tx = 0;
    int poll_cyc[3];
    logic last_poll_busy = 1'b0, prev_strobe0 = 1'b0, prev_hs0 = 1'b0, hs0, strobe0;
    logic [7:0] exp_b;

    always @(negedge clock) begin
        if (!reset) begin
            strobe0 = !bus_rd0 || !bus_wr0;
            if (strobe0) chk("strobe_gap", prev_strobe0, 1'b0);
            if (!bus_cs0 && !bus_wr0) begin
                if (bus_addr0 == REG_CONTROL) begin
                    init_wr0++;
                    chk("init_wdata", bus_wdata0, 8'h00);
                end else if (bus_addr0 == REG_TX) begin
                    tx_wr0++;
                    chk("tx_busy_clear", last_poll_busy, 1'b0);
                    chk("tx_after_poll", polls_since_tx != 0, 1'b1);
                    polls_since_tx = 0;
                    if (tx_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL tx_unexpected actual=%0h required=none", bus_wdata0);
                    end else begin
                        exp_b = tx_q.pop_front();
                        chk("tx_data", bus_wdata0, exp_b);
                    end
                end else begin
                    chk("wr_addr", bus_addr0, REG_TX);
                end
            end
            if (!bus_cs0 && !bus_rd0) begin
                if (bus_addr0 == REG_CONTROL) begin
                    last_poll_busy = model_busy;
                    polls_since_tx++;
                    if (npoll < 3) poll_cyc[npoll] = cyc;
                    npoll++;
                end else if (bus_addr0 == REG_RX) begin
                    rx_rd0++;
                end
            end
            if (prev_hs0) chk("rx_valid_clear", rx_valid0, 1'b0);
            hs0 = rx_valid0 && rx_ready0;
            if (hs0) begin
                if (rx_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rx_unexpected actual=%0h required=none", rx_data0);
                end else begin
                    exp_b = rx_q.pop_front();
                    chk("rx_data", rx_data0, exp_b);
                end
            end
            prev_strobe0 = strobe0;
            prev_hs0     = hs0;

            if (!bus_cs1 && !bus_wr1) begin
                chk("irq_init_addr", bus_addr1, REG_CONTROL);
                chk("irq_init_wdata", bus_wdata1, 8'(1 << CTL_IRQ_ENAB));
            end
            if (!bus_cs1 && !bus_rd1 && bus_addr1 == REG_RX) rx_rd1++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b, input bit track);
        int k;
        tx_valid0 = 1'b1;
        tx_data0  = b;
        for (k = 0; k < 400 && !tx_ready0; k++) tick(1);
        if (!tx_ready0) begin
            timeout_fail("push");
        end else begin
            if (track) tx_q.push_back(b);
            tick(1);
        end
        tx_valid0 = 1'b0;
    endtask

    task automatic wait_tx_drain(input string name);
        int k;
        for (k = 0; k < 400 && tx_q.size() != 0; k++) tick(1);
        if (tx_q.size() != 0) timeout_fail(name);
        tick(2);
    endtask

    typedef struct {
        logic [7:0] data;
        int         busy_cyc;
    } tx_vec_t;

    tx_vec_t    vecs[3];
    logic [7:0] rx_vecs[2];
    int         n0, k;

    initial begin
        vecs[0] = '{data: 8'h55, busy_cyc: 100};
        vecs[1] = '{data: 8'h3C, busy_cyc: 30};
        vecs[2] = '{data: 8'hFF, busy_cyc: 5};
        rx_vecs[0] = 8'hA5;
        rx_vecs[1] = 8'hC3;

        reset = 1'b1;
        tx_valid0 = 1'b0; tx_data0 = 8'h00; rx_ready0 = 1'b1;
        tx_valid1 = 1'b0; tx_data1 = 8'h00; rx_ready1 = 1'b0; irq1 = 1'b0;
        model_busy = 1'b0; rx_load = 1'b0; rx_load_byte = 8'h00; rx_buf1 = 8'h00;
        tick(3);
        chk("rst_cs", bus_cs0, 1'b1);
        chk("rst_rd", bus_rd0, 1'b1);
        chk("rst_wr", bus_wr0, 1'b1);
        chk("rst_addr", bus_addr0, 3'd0);
        chk("rst_wdata", bus_wdata0, 8'h00);
        chk("rst_rx_valid", rx_valid0, 1'b0);
        chk("rst_rx_data", rx_data0, 8'h00);
        chk("rst_overrun", rx_overrun0, 1'b0);
        chk("rst_tx_ready", tx_ready0, 1'b1);
        chk("rst_tx_ready1", tx_ready1, 1'b1);
        reset = 1'b0;

        tick(70);
        chk("init_writes", init_wr0, 1);
        chk("poll_count_min", npoll >= 3, 1'b1);
        chk("poll_period_a", poll_cyc[1] - poll_cyc[0], POLL_GAP + 2);
        chk("poll_period_b", poll_cyc[2] - poll_cyc[1], POLL_GAP + 2);
        chk("no_tx_idle", tx_wr0, 0);

        push(8'h41, 1'b1);
        push(8'h42, 1'b1);
        wait_tx_drain("tx_pair");
        chk("tx_pair_count", tx_wr0, 2);

        for (int i = 0; i < 3; i++) begin
            model_busy = 1'b1;
            tick(1);
            n0 = tx_wr0;
            push(vecs[i].data, 1'b1);
            tick(vecs[i].busy_cyc);
            chk("tx_held_busy", tx_wr0, n0);
            model_busy = 1'b0;
            wait_tx_drain("tx_vec");
            chk("tx_vec_count", tx_wr0, n0 + 1);
        end

        model_busy = 1'b1;
        tick(1);
        n0 = tx_wr0;
        for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i), 1'b1);
        chk("tx_ready_full", tx_ready0, 1'b0);
        tx_valid0 = 1'b1;
        tx_data0  = 8'hB4;
        tick(5);
        chk("tx_ready_held", tx_ready0, 1'b0);
        chk("no_tx_while_full", tx_wr0, n0);
        model_busy = 1'b0;
        push(8'hB4, 1'b1);
        chk("fifth_after_pop", tx_wr0 > n0, 1'b1);
        wait_tx_drain("tx_full");
        chk("tx_full_count", tx_wr0, n0 + 5);

        for (int i = 0; i < 2; i++) begin
            n0 = rx_rd0;
            rx_q.push_back(rx_vecs[i]);
            rx_load_byte = rx_vecs[i];
            rx_load = 1'b1;
            tick(1);
            rx_load = 1'b0;
            for (k = 0; k < 100 && rx_q.size() != 0; k++) tick(1);
            if (rx_q.size() != 0) timeout_fail("rx_vec");
            tick(2);
            chk("rx_read_count", rx_rd0, n0 + 1);
            chk("rx_valid_idle", rx_valid0, 1'b0);
        end

        // dut1: align to the GAP state right after a poll, then pulse irq
        rx_buf1 = 8'h5A;
        for (k = 0; k < 100 && !(!bus_rd1 && bus_addr1 == REG_CONTROL); k++) tick(1);
        if (k == 100) timeout_fail("irq_poll_align");
        tick(2);
        irq1 = 1'b1;
        tick(1);
        irq1 = 1'b0;
        chk("irq_rd_strobe", bus_rd1, 1'b0);
        chk("irq_rd_addr", bus_addr1, REG_RX);
        tick(1);
        chk("irq_rx_valid", rx_valid1, 1'b1);
        chk("irq_rx_data", rx_data1, 8'h5A);
        tick(5);
        chk("irq_no_overrun_yet", rx_overrun1, 1'b0);
        rx_buf1 = 8'h77;
        irq1 = 1'b1;
        tick(1);
        irq1 = 1'b0;
        tick(3);
        chk("irq_overrun", rx_overrun1, 1'b1);
        chk("irq_held_data", rx_data1, 8'h5A);
        chk("irq_single_read", rx_rd1, 1);

        // Reset landing in the middle of a Tx buffer write
        model_busy = 1'b1;
        tick(1);
        n0 = tx_wr0;
        push(8'h99, 1'b0);
        push(8'h66, 1'b0);
        model_busy = 1'b0;
        for (k = 0; k < 100 && !(!bus_wr0 && bus_addr0 == REG_TX); k++) tick(1);
        if (k == 100) timeout_fail("tx_wr_align");
        #2;
        reset = 1'b1;
        #1;
        chk("async_cs", bus_cs0, 1'b1);
        chk("async_wr", bus_wr0, 1'b1);
        chk("async_rd", bus_rd0, 1'b1);
        tick(3);
        reset = 1'b0;
        chk("post_rst_tx_ready", tx_ready0, 1'b1);
        chk("post_rst_overrun", rx_overrun1, 1'b0);
        tick(60);
        chk("init_rerun", init_wr0, 2);
        chk("fifo_flushed", tx_wr0, n0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
